vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ACTIVE_H, 640, active pixels per line.
- ACTIVE_V, 480, active lines per frame.
- H_BP, 99, pixel clocks from the hsync rising edge to the first active pixel.
- V_BP, 25, lines from the first post-vsync line to the first active line.
- H_TOTAL, 819, expected pixel clocks per line.
- V_TOTAL, 509, expected lines per frame.
REQ-002 Ports, one per line: name, direction, width, meaning.
- dclk, in, 1, pixel clock; the only clock.
- rst, in, 1, asynchronous active-high reset.
- hsync_in, in, 1, horizontal sync, active low.
- vsync_in, in, 1, vertical sync, active low.
- rgb_in, in, 3, {red, green, blue} pixel data.
- X, out, 10, column of the current pixel.
- Y, out, 10, row of the current pixel.
- rgb_out, out, 3, captured pixel.
- pixel_valid, out, 1, X/Y/rgb_out hold an active pixel.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- locked, out, 1, measured timing matches the parameters.
- h_period, out, 10, last measured line length in clocks.
- v_lines, out, 10, last measured lines per frame.

Function
REQ-003 Stage 1 registers hsync_in, vsync_in and rgb_in on each dclk rising edge; all edge detection uses the stage-1 values and their one-cycle delayed copies.
REQ-004 Stage 2 registers every output, giving a fixed 2-cycle latency from the input pins to X/Y/rgb_out/pixel_valid/frame_start.
REQ-005 hpos (10 bit) is cleared on the cycle a stage-1 hsync rising edge is seen, otherwise it increments, saturating at 1023.
REQ-006 On an hsync rising edge, h_period takes the previous hpos+1, saturating at 1023.
REQ-007 A stage-1 vsync rising edge sets vpend.
- On the next hsync rising edge: vline=0, v_lines takes the old vline+1, and vpend clears.
- On other hsync rising edges vline increments, saturating at 1023.
- Same-cycle vsync and hsync rising edges count as vsync first: vline=0 on that edge.
REQ-008 The active region is H_BP <= hpos < H_BP+ACTIVE_H and V_BP <= vline < V_BP+ACTIVE_V.
REQ-009 When active and locked: X=hpos-H_BP, Y=vline-V_BP, rgb_out=stage-1 rgb, pixel_valid=1.
REQ-010 When not active, or not locked: X=0, Y=0, rgb_out=0, pixel_valid=0.
REQ-011 frame_start=1 exactly when REQ-009 applies with X=0 and Y=0.
REQ-012 Lock state machine, states SEARCH, CHECK, LOCKED; locked=1 only in LOCKED.
- SEARCH -> CHECK at the first vsync-driven vline reset.
- CHECK -> LOCKED when a complete frame ends with v_lines==V_TOTAL and every h_period measured in that frame equals H_TOTAL.
- CHECK -> SEARCH on any mismatch.
- LOCKED -> SEARCH on any h_period!=H_TOTAL, on any v_lines!=V_TOTAL, or when hpos reaches 1023 (sync loss).
REQ-013 A mismatch drops locked in the cycle after the offending edge is detected; the pixel outputs follow REQ-010 from that point.
REQ-014 Widths: all counters are 10 bit and saturate, never wrap; X/Y subtraction is only evaluated inside the active region.

Reset
REQ-015 While rst=1, asynchronously: all outputs 0, hpos=1023, vline=1023, vpend=0, state SEARCH, stage-1 sync registers=1 (idle), stage-1 rgb=0.
REQ-016 Deasserting rst mid-line restarts acquisition; the first hsync rising edge yields h_period=1023 (saturated) and is never counted as a match.

Verification
REQ-017 Drive standard 640x480 timing (hsync low at clocks 32-79 of an 819-clock line; vsync low on lines 1-3 of 509) for 3 frames -> locked=1 from the end of frame 2 (second complete frame); h_period=819; v_lines=509.
REQ-018 Locked, with rgb_in=3'b101 only at the generator pixel at hc=179+5, vc=29+7 -> pixel_valid=1, X=5, Y=7, rgb_out=3'b101, 2 cycles later.
REQ-019 Locked, one line stretched to 820 clocks -> h_period=820, locked=0 the next cycle, pixel_valid=0 until relock two frames later.
REQ-020 Locked, hsync held high for 1100 clocks -> hpos saturates at 1023, locked=0, outputs 0, no counter wrap.
REQ-021 Same-cycle hsync and vsync rising edges -> vline=0 and v_lines updated; rst pulsed mid-frame -> all outputs 0 immediately, and relock after 2 good frames.
REQ-022 Locked; check frame_start and pixel_valid per frame -> exactly one frame_start per frame; pixel_valid high for exactly 307200 cycles per frame.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: measures incoming VGA sync timing, locks when it matches the
// expected line/frame lengths, and emits pixel coordinates with captured colour.
module vga_capture #(
    parameter int ACTIVE_H = 640,
    parameter int ACTIVE_V = 480,
    parameter int H_BP     = 99,
    parameter int V_BP     = 25,
    parameter int H_TOTAL  = 819,
    parameter int V_TOTAL  = 509
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic [2:0] rgb_out,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] h_period,
    output logic [9:0] v_lines
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;
    localparam logic [9:0] HB = 10'(H_BP);
    localparam logic [9:0] HE = 10'(H_BP + ACTIVE_H);
    localparam logic [9:0] VB = 10'(V_BP);
    localparam logic [9:0] VE = 10'(V_BP + ACTIVE_V);
    localparam logic [9:0] HT = 10'(H_TOTAL);
    localparam logic [9:0] VT = 10'(V_TOTAL);
    state_e     state_q;
    logic       hs_q, vs_q, hs_dq, vs_dq, vpend_q, vpend_d;
    logic [2:0] rgb_q;
    logic [9:0] hpos_q, hpos_d, vline_q, vline_d, hp_meas, vl_meas;
    logic       h_rise, v_rise, v_reset, bad, act, pix_ok;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3ff) ? v : v + 10'd1;
    endfunction

    // hpos_d/vline_d are the counts for the pixel currently held in stage 1
    always_comb begin
        h_rise  = hs_q & ~hs_dq;
        v_rise  = vs_q & ~vs_dq;
        v_reset = h_rise & (vpend_q | v_rise);
        hpos_d  = h_rise ? '0 : sat_inc(hpos_q);
        vline_d = v_reset ? '0 : h_rise ? sat_inc(vline_q) : vline_q;
        vpend_d = ~h_rise & (vpend_q | v_rise);
        hp_meas = sat_inc(hpos_q);
        vl_meas = sat_inc(vline_q);
        bad     = (state_q != SEARCH) & ((h_rise & (hp_meas != HT)) | (v_reset & (vl_meas != VT)) | (hpos_d == 10'h3ff));
        act     = (hpos_d >= HB) & (hpos_d < HE) & (vline_d >= VB) & (vline_d < VE);
        pix_ok  = act & (state_q == LOCKED) & ~bad;
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hs_dq       <= 1'b1;
            vs_dq       <= 1'b1;
            rgb_q       <= '0;
            hpos_q      <= '1;
            vline_q     <= '1;
            vpend_q     <= 1'b0;
            state_q     <= SEARCH;
            locked      <= 1'b0;
            X           <= '0;
            Y           <= '0;
            rgb_out     <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
        end else begin
            hs_q        <= hsync_in;
            vs_q        <= vsync_in;
            hs_dq       <= hs_q;
            vs_dq       <= vs_q;
            rgb_q       <= rgb_in;
            hpos_q      <= hpos_d;
            vline_q     <= vline_d;
            vpend_q     <= vpend_d;
            h_period    <= h_rise ? hp_meas : h_period;
            v_lines     <= v_reset ? vl_meas : v_lines;
            state_q     <= bad ? SEARCH : !v_reset ? state_q : (state_q == SEARCH) ? CHECK : LOCKED;
            locked      <= ~bad & ((state_q == LOCKED) | ((state_q == CHECK) & v_reset));
            X           <= pix_ok ? hpos_d - HB : '0;
            Y           <= pix_ok ? vline_d - VB : '0;
            rgb_out     <= pix_ok ? rgb_q : '0;
            pixel_valid <= pix_ok;
            frame_start <= pix_ok & (hpos_d == HB) & (vline_d == VB);
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench driving a scaled 40x30 sync pattern
// (16x20 active) through lock, pixel capture, timing faults and reset.
module tb_vga_capture;
    logic       dclk = 1'b0, rst = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [2:0] rgb_in = 3'b000;
    logic [9:0] X, Y, h_period, v_lines;
    logic [2:0] rgb_out;
    logic       pixel_valid, frame_start, locked;
    int tests = 0, fails = 0, steps = 0, pv_cnt = 0, fs_cnt = 0;
    int fr = 0, vc = 0, hc = 0, lf = 0, lv = 0, lh = 0;

    always #5 dclk = ~dclk;

    vga_capture #(
        .ACTIVE_H(16), .ACTIVE_V(20), .H_BP(10), .V_BP(3), .H_TOTAL(40), .V_TOTAL(30)
    ) dut (
        .dclk(dclk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .X(X), .Y(Y), .rgb_out(rgb_out), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked), .h_period(h_period), .v_lines(v_lines)
    );

    function automatic int hlen(int f, int v);
        return (f == 3 && v == 10) ? 41 : (f == 5 && v == 10) ? 1110 : 40;
    endfunction

    // frames 6 and 7 delay the vsync rise onto the hsync rise of line 4
    task automatic step();
        hsync_in = !(hc >= 4 && hc < 10);
        vsync_in = !((vc >= 1 && vc <= 3) || ((fr == 6 || fr == 7) && vc == 4 && hc < 10));
        rgb_in   = (fr == 1 && vc == 14 && hc == 25) ? 3'b101 : 3'b000;
        @(posedge dclk);
        #1;
        pv_cnt += int'(pixel_valid);
        fs_cnt += int'(frame_start);
        lf = fr; lv = vc; lh = hc;
        steps++;
        hc++;
        if (hc == hlen(fr, vc)) begin
            hc = 0;
            vc++;
            if (vc == 30) begin
                vc = 0;
                fr++;
            end
        end
    endtask

    task automatic run_past(int f, int v, int h);
        do begin
            step();
            if (steps > 60000) begin
                $display("FAIL run_past: step budget exhausted before %0d/%0d/%0d", f, v, h);
                $fatal(1, "bench stopped");
            end
        end while (!(lf == f && lv == v && lh == h));
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge dclk);
        #1;
        check("reset_outputs", 64'({X, Y, rgb_out, pixel_valid, frame_start, locked, h_period, v_lines}), 64'd0);
        rst = 1'b0;
        run_past(0, 0, 10);
        check("h_period_before_edge", 64'(h_period), 64'd0);
        run_past(0, 0, 11);
        check("h_period_first_saturated", 64'(h_period), 64'd1023);
        run_past(0, 1, 11);
        check("h_period_line", 64'(h_period), 64'd40);
        run_past(0, 4, 11);
        check("v_lines_first_saturated", 64'(v_lines), 64'd1023);
        check("locked_first_vsync", 64'(locked), 64'd0);
        run_past(1, 4, 10);
        check("locked_before_frame_end", 64'(locked), 64'd0);
        run_past(1, 4, 11);
        check("locked_after_frame", 64'(locked), 64'd1);
        check("v_lines_frame", 64'(v_lines), 64'd30);
        check("h_period_locked", 64'(h_period), 64'd40);
        run_past(1, 14, 25);
        check("pixel_x4", 64'({pixel_valid, X, Y, rgb_out}), 64'({1'b1, 10'd4, 10'd7, 3'b000}));
        run_past(1, 14, 26);
        check("pixel_x5_marked", 64'({pixel_valid, X, Y, rgb_out}), 64'({1'b1, 10'd5, 10'd7, 3'b101}));
        run_past(1, 14, 27);
        check("pixel_x6", 64'({pixel_valid, X, Y, rgb_out}), 64'({1'b1, 10'd6, 10'd7, 3'b000}));
        run_past(1, 29, 39);
        pv_cnt = 0;
        fs_cnt = 0;
        run_past(2, 7, 21);
        check("frame_start_origin", 64'({frame_start, pixel_valid, X, Y}), 64'({1'b1, 1'b1, 10'd0, 10'd0}));
        run_past(2, 29, 39);
        check("pixel_valid_per_frame", 64'(pv_cnt), 64'd320);
        check("frame_start_per_frame", 64'(fs_cnt), 64'd1);
        run_past(3, 11, 10);
        check("long_line_before", 64'({locked, h_period}), 64'({1'b1, 10'd40}));
        run_past(3, 11, 11);
        check("long_line_unlock", 64'({locked, h_period}), 64'({1'b0, 10'd41}));
        pv_cnt = 0;
        run_past(5, 4, 10);
        check("relock_pending", 64'(locked), 64'd0);
        check("no_pixels_unlocked", 64'(pv_cnt), 64'd0);
        run_past(5, 4, 11);
        check("relock", 64'(locked), 64'd1);
        run_past(5, 10, 1033);
        check("hold_before_sat", 64'(locked), 64'd1);
        run_past(5, 10, 1034);
        check("sync_loss_unlock", 64'(locked), 64'd0);
        run_past(5, 10, 1100);
        check("sync_loss_outputs", 64'({X, Y, rgb_out, pixel_valid, frame_start, locked}), 64'd0);
        run_past(5, 11, 11);
        check("h_period_no_wrap", 64'(h_period), 64'd1023);
        run_past(6, 4, 11);
        check("same_edge_v_lines", 64'({locked, v_lines}), 64'({1'b0, 10'd30}));
        run_past(6, 5, 11);
        check("same_edge_vpend_cleared", 64'(v_lines), 64'd30);
        run_past(7, 4, 11);
        check("same_edge_lock", 64'({locked, v_lines}), 64'({1'b1, 10'd30}));
        run_past(7, 7, 21);
        check("same_edge_origin", 64'({frame_start, pixel_valid, X, Y}), 64'({1'b1, 1'b1, 10'd0, 10'd0}));
        run_past(7, 15, 25);
        check("pixel_before_reset", 64'({pixel_valid, X, Y}), 64'({1'b1, 10'd4, 10'd8}));
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({X, Y, rgb_out, pixel_valid, frame_start, locked, h_period, v_lines}), 64'd0);
        repeat (3) step();
        rst = 1'b0;
        run_past(7, 16, 11);
        check("post_reset_h_period", 64'({locked, h_period}), 64'({1'b0, 10'd1023}));
        run_past(8, 4, 11);
        check("post_reset_v_lines", 64'({locked, v_lines}), 64'({1'b0, 10'd1023}));
        run_past(9, 4, 10);
        check("post_reset_pending", 64'(locked), 64'd0);
        run_past(9, 4, 11);
        check("post_reset_relock", 64'({locked, v_lines}), 64'({1'b1, 10'd30}));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
